// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive frame FIFO: buffers MAC beats, commits good frames,
// rolls back bad or overflowed ones, and streams committed beats out with FWFT.
module eth_rx_frame_fifo #(
    parameter int unsigned DEPTH = 512
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] drop_count,
    output logic [15:0] frame_count,
    output logic        overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;

    logic        ready_q;
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        commit_ptr_q, commit_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    logic        ovf_flag_q, ovf_flag_d;
    logic [15:0] drop_q, drop_d;
    logic [15:0] frame_q, frame_d;
    logic        overflow_q, overflow_d;
    logic        mid_vld_q, mid_vld_d;
    logic        out_vld_q, out_vld_d;
    logic [72:0] out_data_q, out_data_d;

    logic [72:0] ram_q [DEPTH];
    logic [72:0] rd_data_q;

    logic accept, full, discard, wr_en, commit, rollback;
    logic avail, out_ready, rd_en;

    // Full counts uncommitted beats too, since they occupy RAM until rollback.
    assign accept   = s_axis_tvalid & ready_q;
    assign full     = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign discard  = ovf_flag_q | full;
    assign wr_en    = accept & ~discard;
    assign commit   = accept & s_axis_tlast & ~s_axis_tuser & ~discard;
    assign rollback = accept & s_axis_tlast & (s_axis_tuser | discard);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        ovf_flag_d   = ovf_flag_q;
        drop_d       = drop_q;
        frame_d      = frame_q;
        overflow_d   = overflow_q;
        if (rollback) begin
            wr_ptr_d   = commit_ptr_q;
            ovf_flag_d = 1'b0;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            if (discard) overflow_d = 1'b1;
        end else if (commit) begin
            wr_ptr_d     = wr_ptr_q + ptr_t'(1);
            commit_ptr_d = wr_ptr_q + ptr_t'(1);
            frame_d      = frame_q + 16'd1;
        end else if (accept) begin
            if (full) ovf_flag_d = 1'b1;
            if (wr_en) wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
    end

    // Two-stage read pipeline: RAM output register (mid) feeding the output register.
    assign avail     = commit_ptr_q != rd_ptr_q;
    assign out_ready = ~out_vld_q | m_axis_tready;
    assign rd_en     = avail & (~mid_vld_q | out_ready);

    always_comb begin
        rd_ptr_d   = rd_en ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        mid_vld_d  = mid_vld_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        if (out_ready) begin
            out_vld_d = mid_vld_q;
            if (mid_vld_q) out_data_d = rd_data_q;
            mid_vld_d = 1'b0;
        end
        if (rd_en) mid_vld_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (wr_en) ram_q[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (rd_en) rd_data_q <= ram_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ready_q      <= 1'b0;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            ovf_flag_q   <= 1'b0;
            drop_q       <= '0;
            frame_q      <= '0;
            overflow_q   <= 1'b0;
            mid_vld_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            out_data_q   <= '0;
        end else begin
            ready_q      <= 1'b1;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ovf_flag_q   <= ovf_flag_d;
            drop_q       <= drop_d;
            frame_q      <= frame_d;
            overflow_q   <= overflow_d;
            mid_vld_q    <= mid_vld_d;
            out_vld_q    <= out_vld_d;
            out_data_q   <= out_data_d;
        end
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tlast  = out_data_q[72];
    assign m_axis_tkeep  = out_data_q[71:64];
    assign m_axis_tdata  = out_data_q[63:0];
    assign drop_count    = drop_q;
    assign frame_count   = frame_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Scoreboard bench for eth_rx_frame_fifo: drivers queue expected beats, a
// negedge monitor pops and compares every output handshake.
`timescale 1ns/1ps
module tb_eth_rx_frame_fifo;

    localparam int unsigned DEPTH = 16;

    logic        clock = 1'b0;
    logic        resetn;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast, s_tuser, s_tvalid, s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast, m_tvalid, m_tready;
    logic [15:0] drop_count, frame_count;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int rdy_cfg = 1;  // 0: hold low, 1: hold high, 2: toggle each cycle
    logic [72:0] exp_q [$];
    logic        prev_stall;
    logic [72:0] prev_beat;
    logic [72:0] cur;

    always #5 clock = ~clock;

    eth_rx_frame_fifo #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tlast (s_tlast),
        .s_axis_tuser (s_tuser),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tlast (m_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .drop_count   (drop_count),
        .frame_count  (frame_count),
        .overflow     (overflow)
    );

    assign cur = {m_tlast, m_tkeep, m_tdata};

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (rdy_cfg)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = ~m_tready;
            endcase
        end
    end

    always @(negedge clock) begin
        if (!resetn) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", m_tvalid, 1);
                check("stall_data", cur, prev_beat);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h expected none", cur);
                end else begin
                    check("beat", cur, exp_q.pop_front());
                end
            end
            prev_stall <= m_tvalid && !m_tready;
            prev_beat  <= cur;
        end
    end

    task automatic send_frame(input int n, input logic [31:0] tag, input logic [7:0] last_keep,
                              input logic user, input bit expect_pass);
        for (int i = 0; i < n; i++) begin
            if (expect_pass)
                exp_q.push_back({i == n - 1, (i == n - 1) ? last_keep : 8'hFF, tag, i[31:0]});
        end
        for (int i = 0; i < n; i++) begin
            s_tdata  = {tag, i[31:0]};
            s_tkeep  = (i == n - 1) ? last_keep : 8'hFF;
            s_tlast  = (i == n - 1);
            s_tuser  = (i == n - 1) ? user : 1'b0;
            s_tvalid = 1'b1;
            @(posedge clock);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while ((exp_q.size() != 0 || m_tvalid) && cyc < 400) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("drain_done", exp_q.size() == 0, 1);
        repeat (5) @(posedge clock);
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        exp_q.delete();
        release_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        resetn   = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        s_tvalid = 1'b0;
        #12;
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_data", cur, 0);
        check("rst_drop", drop_count, 0);
        check("rst_frame", frame_count, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        #1;
        check("ready_before_edge", s_tready, 0);
        @(posedge clock);
        #1;
        check("ready_after_edge", s_tready, 1);

        // Good 8-beat frame with FWFT latency check
        rdy_cfg = 1;
        @(posedge clock);
        #1;
        send_frame(8, 32'h0, 8'h0F, 1'b0, 1'b1);
        check("lat_n", m_tvalid, 0);
        @(posedge clock);
        #1;
        check("lat_n1", m_tvalid, 0);
        @(posedge clock);
        #1;
        check("lat_n2", m_tvalid, 1);
        wait_drain();
        check("good_frame_count", frame_count, 1);
        check("good_drop_count", drop_count, 0);

        // Bad frame followed by good frame
        do_reset();
        send_frame(6, 32'h100, 8'hFF, 1'b1, 1'b0);
        send_frame(4, 32'h200, 8'h03, 1'b0, 1'b1);
        wait_drain();
        check("bad_drop_count", drop_count, 1);
        check("bad_frame_count", frame_count, 1);
        check("bad_overflow", overflow, 0);

        // Overflow with consumer stalled
        rdy_cfg = 0;
        do_reset();
        send_frame(20, 32'h300, 8'hFF, 1'b0, 1'b0);
        send_frame(3, 32'h400, 8'h01, 1'b0, 1'b1);
        repeat (4) @(posedge clock);
        #1;
        check("ovf_overflow", overflow, 1);
        check("ovf_drop_count", drop_count, 1);
        check("ovf_frame_count", frame_count, 1);
        check("ovf_tvalid_held", m_tvalid, 1);
        check("ovf_s_tready", s_tready, 1);
        rdy_cfg = 1;
        wait_drain();

        // Back-pressure with toggling ready
        do_reset();
        rdy_cfg = 2;
        send_frame(5, 32'h500, 8'h7F, 1'b0, 1'b1);
        send_frame(5, 32'h501, 8'h7F, 1'b0, 1'b1);
        send_frame(5, 32'h502, 8'h7F, 1'b0, 1'b1);
        wait_drain();
        check("bp_frame_count", frame_count, 3);
        rdy_cfg = 1;

        // Pointer wrap over many frames
        do_reset();
        for (int f = 0; f < 40; f++) send_frame(7, 32'h1000 + f, 8'h3F, 1'b0, 1'b1);
        wait_drain();
        check("wrap_frame_count", frame_count, 40);
        check("wrap_drop_count", drop_count, 0);
        check("wrap_overflow", overflow, 0);

        // Reset during third output beat
        do_reset();
        send_frame(8, 32'h600, 8'hFF, 1'b0, 1'b1);
        cyc = 0;
        while (!m_tvalid && cyc < 20) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("mid_tvalid_seen", m_tvalid, 1);
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_tvalid", m_tvalid, 0);
        check("mid_rst_frame", frame_count, 0);
        check("mid_rst_drop", drop_count, 0);
        check("mid_rst_s_tready", s_tready, 0);
        release_reset();
        send_frame(4, 32'h700, 8'h0F, 1'b0, 1'b1);
        wait_drain();
        check("post_rst_frame", frame_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
